// File: rtl/arm_cond_pkg.sv
// Shared ARM condition-code encodings and NZCV flag bit positions for the condition unit.
package arm_cond_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/arm_cond_eval.sv
// Pure combinational ARM condition evaluator: (cond, {N,Z,C,V}) -> pass.
module arm_cond_eval
    import arm_cond_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       pass_o
);

    logic n, z, c, v;

    assign n = nzcv_i[FLAG_N];
    assign z = nzcv_i[FLAG_Z];
    assign c = nzcv_i[FLAG_C];
    assign v = nzcv_i[FLAG_V];

    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            COND_EQ: pass_o = z;
            COND_NE: pass_o = ~z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = ~c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = ~n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = ~v;
            COND_HI: pass_o = c & ~z;
            COND_LS: pass_o = ~c | z;
            COND_GE: pass_o = (n == v);
            COND_LT: pass_o = (n != v);
            COND_GT: pass_o = ~z & (n == v);
            COND_LE: pass_o = z | (n != v);
            COND_AL: pass_o = 1'b1;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_status_cond_unit.sv
// ARM condition unit: NZCV status register, in-flight flag-setter tracking and ID stall.
// Optional EX->ID flag forwarding is enabled by defining ARM_FLAG_FWD_EN.
module arm_status_cond_unit
    import arm_cond_pkg::*;
#(
    parameter  int PIPE_DEPTH = 2,
    localparam int CNT_W      = $clog2(PIPE_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_cond,
    input  logic             id_s,
    input  logic             flush,
    input  logic             ex_sr_we,
    input  logic [3:0]       ex_nzcv,
    output logic             id_cond_pass,
    output logic             id_stall,
    output logic [3:0]       sr_nzcv,
    output logic [CNT_W-1:0] pend_cnt
);

    logic [3:0]       sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       eval_nzcv;
    logic             fwd;
    logic             issue;
    logic             retire;
    logic             uncond;

`ifdef ARM_FLAG_FWD_EN
    // The sole outstanding flag-setter is writing now, so its flags are already final.
    assign fwd       = (cnt_q == CNT_W'(1)) & ex_sr_we;
    assign eval_nzcv = fwd ? ex_nzcv : sr_q;
`else
    assign fwd       = 1'b0;
    assign eval_nzcv = sr_q;
`endif

    arm_cond_eval u_eval (
        .cond_i (id_cond),
        .nzcv_i (eval_nzcv),
        .pass_o (id_cond_pass)
    );

    assign uncond   = (id_cond == COND_AL) | (id_cond == COND_NV);
    assign id_stall = id_valid & (cnt_q != '0) & ~uncond & ~fwd;
    assign issue    = id_valid & id_s & ~id_stall & ~flush;
    assign retire   = ex_sr_we;

    always_comb begin
        sr_d = ex_sr_we ? ex_nzcv : sr_q;
        cnt_d = cnt_q;
        // Counter saturates at both ends; the illegal cases are caught by the assertions.
        if (flush) begin
            cnt_d = '0;
        end else if (issue && !retire && cnt_q != CNT_W'(PIPE_DEPTH)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (retire && !issue && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign sr_nzcv  = sr_q;
    assign pend_cnt = cnt_q;

    a_no_issue_at_max: assert property (@(posedge clk) disable iff (rst)
        !(issue && !retire && cnt_q == CNT_W'(PIPE_DEPTH)));
    a_no_retire_at_zero: assert property (@(posedge clk) disable iff (rst)
        !(retire && !issue && cnt_q == '0));

endmodule
